// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage: register file, forwarding bus, retire counter, halt
module writeback_unit #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            isld,
  input  logic            iswb,
  input  logic [15:0]     instr,
  input  logic [DW-1:0]   aluresult,
  input  logic [DW-1:0]   ldresult,
  input  logic [3:0]      rs1_addr,
  input  logic [3:0]      rs2_addr,
  output logic [DW-1:0]   rs1_data,
  output logic [DW-1:0]   rs2_data,
  output logic [DW+3:0]   rdvalwb,
  output logic            wb_valid,
  output logic [CW-1:0]   retired,
  output logic            halted
);

  localparam logic [3:0] OP_HALT = 4'hF;

  logic [DW-1:0] regs [16];
  logic [3:0]    opcode;
  logic [3:0]    rd;
  logic [DW-1:0] wb_value;
  logic          is_bubble;
  logic          do_write;
  logic          do_retire;

  assign opcode    = instr[15:12];
  assign rd        = instr[11:8];
  assign is_bubble = (instr == 16'h0000);
  assign wb_value  = isld ? ldresult : aluresult;
  assign do_write  = reset && iswb && !halted && (opcode != OP_HALT) && (rd != 4'd0);
  assign do_retire = !halted && !is_bubble;

  // Reads see the value being written this cycle so decode never picks up a stale register.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (do_write && (rs1_addr == rd)) rs1_data = wb_value;
    if (do_write && (rs2_addr == rd)) rs2_data = wb_value;
    if (rs1_addr == 4'd0) rs1_data = '0;
    if (rs2_addr == 4'd0) rs2_data = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      rdvalwb  <= '0;
      wb_valid <= 1'b0;
      retired  <= '0;
      halted   <= 1'b0;
    end else begin
      wb_valid <= do_write;
      if (do_write) begin
        regs[rd] <= wb_value;
        rdvalwb  <= {rd, wb_value};
      end
      if (do_retire) begin
        if (retired != {CW{1'b1}}) retired <= retired + CW'(1);
        if (opcode == OP_HALT) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - randomized and directed self-checking bench for writeback_unit
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        isld, iswb;
  logic [15:0] instr, aluresult, ldresult;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [15:0] rs1_data, rs2_data, rs1_data4, rs2_data4;
  logic [19:0] rdvalwb, rdvalwb4;
  logic        wb_valid, wb_valid4, halted, halted4;
  logic [15:0] retired;
  logic [3:0]  retired4;

  int checks = 0;
  int passed = 0;

  // reference state
  logic [15:0] m_regs [16];
  logic [19:0] m_rdval;
  logic        m_wbv, m_halted;
  int          m_ret, m_ret4;

  writeback_unit #(.DW(16), .CW(16)) dut (
    .clk(clk), .reset(reset), .isld(isld), .iswb(iswb), .instr(instr),
    .aluresult(aluresult), .ldresult(ldresult), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rdvalwb(rdvalwb), .wb_valid(wb_valid),
    .retired(retired), .halted(halted)
  );

  writeback_unit #(.DW(16), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .isld(isld), .iswb(iswb), .instr(instr),
    .aluresult(aluresult), .ldresult(ldresult), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data4), .rs2_data(rs2_data4), .rdvalwb(rdvalwb4), .wb_valid(wb_valid4),
    .retired(retired4), .halted(halted4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_rdval = 20'h0; m_wbv = 1'b0; m_halted = 1'b0; m_ret = 0; m_ret4 = 0;
  endtask

  function automatic logic [15:0] exp_read(input logic [3:0] a, input logic wr,
                                          input logic [3:0] d, input logic [15:0] v);
    if (a == 4'd0) return 16'h0;
    if (wr && a == d) return v;
    return m_regs[a];
  endfunction

  // One cycle: drive at negedge, check reads combinationally, clock, update model, check outputs.
  task automatic step(input logic rst, input logic [15:0] ins, input logic wb, input logic ld,
                      input logic [15:0] alu, input logic [15:0] ldv,
                      input logic [3:0] a1, input logic [3:0] a2);
    logic        wr;
    logic [3:0]  d;
    logic [15:0] v;
    @(negedge clk);
    reset = rst; instr = ins; iswb = wb; isld = ld; aluresult = alu; ldresult = ldv;
    rs1_addr = a1; rs2_addr = a2;
    d  = ins[11:8];
    v  = ld ? ldv : alu;
    wr = rst && wb && !m_halted && ins[15:12] != 4'hF && d != 4'd0;
    #1;
    chk("rs1_data", rs1_data, exp_read(a1, wr, d, v));
    chk("rs2_data", rs2_data, exp_read(a2, wr, d, v));
    chk("rs1_data_cw4", rs1_data4, exp_read(a1, wr, d, v));
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      m_wbv = wr;
      if (wr) begin
        m_regs[d] = v;
        m_rdval = {d, v};
      end
      if (!m_halted && ins != 16'h0000) begin
        m_ret  = (m_ret  < 65535) ? m_ret + 1  : m_ret;
        m_ret4 = (m_ret4 < 15)    ? m_ret4 + 1 : m_ret4;
        if (ins[15:12] == 4'hF) m_halted = 1'b1;
      end
    end
    #1;
    chk("wb_valid", wb_valid, m_wbv);
    chk("rdvalwb", rdvalwb, m_rdval);
    chk("retired", retired, m_ret);
    chk("retired_cw4", retired4, m_ret4);
    chk("halted", halted, m_halted);
  endtask

  initial begin
    logic [15:0] ins;
    logic [3:0]  op;
    reset = 1'b0; isld = 1'b0; iswb = 1'b1; instr = 16'h1400;
    aluresult = 16'hDEAD; ldresult = 16'hBEEF; rs1_addr = 4'd0; rs2_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("reset_wb_valid", wb_valid, 1'b0);
    chk("reset_rdvalwb", rdvalwb, 20'h0);
    chk("reset_retired", retired, 16'h0);
    chk("reset_halted", halted, 1'b0);

    // first committed write after reset, then readback of R3
    step(1'b1, 16'h1300, 1'b1, 1'b0, 16'h1234, 16'h0000, 4'd3, 4'd0);
    chk("req031_rdvalwb", rdvalwb, 20'h31234);
    chk("req031_retired", retired, 16'd1);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 4'd3, 4'd0);
    chk("req031_wbvalid_drop", wb_valid, 1'b0);
    // load with same-cycle bypass into R5
    step(1'b1, 16'h2500, 1'b1, 1'b1, 16'h0004, 16'hA5A5, 4'd5, 4'd3);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 4'd5, 4'd0);
    chk("req032_r5", rs1_data, 16'hA5A5);
    // rd=0 never writes but still retires
    step(1'b1, 16'h1000, 1'b1, 1'b0, 16'hFFFF, 16'h0, 4'd0, 4'd0);
    chk("req033_rs1_r0", rs1_data, 16'h0);
    // reset mid-stream discards the concurrent instruction
    step(1'b1, 16'h1300, 1'b1, 1'b0, 16'h1234, 16'h0, 4'd3, 4'd4);
    step(1'b0, 16'h1400, 1'b1, 1'b0, 16'h7777, 16'h0, 4'd3, 4'd4);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 4'd3, 4'd4);
    chk("req035_r3", rs1_data, 16'h0);
    chk("req035_r4", rs2_data, 16'h0);

    // CW=4 saturation with interleaved bubbles
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h1100 | 16'(i), 1'b1, 1'b0, 16'(i * 3), 16'h0, 4'd1, 4'(i));
      step(1'b1, 16'h0000, 1'b1, 1'b0, 16'hAAAA, 16'h0, 4'd1, 4'd2);
    end
    chk("req036_retired_cw4", retired4, 4'hF);
    chk("req036_retired_cw16", retired, 16'd20);

    // halt, then further instructions are ignored
    step(1'b1, 16'hF700, 1'b1, 1'b0, 16'h5555, 16'h0, 4'd7, 4'd0);
    chk("req034_halted", halted, 1'b1);
    step(1'b1, 16'h1300, 1'b1, 1'b0, 16'h9999, 16'h0, 4'd7, 4'd3);
    chk("req034_r7", rs1_data, 16'h0);
    chk("req034_wb_valid", wb_valid, 1'b0);

    // random traffic with occasional reset and halt
    for (int i = 0; i < 400; i++) begin
      op  = 4'($urandom_range(1, 14));
      if ($urandom_range(0, 39) == 0) op = 4'hF;
      ins = {op, 4'($urandom), 8'($urandom)};
      if ($urandom_range(0, 7) == 0) ins = 16'h0000;
      step(($urandom_range(0, 29) != 0), ins, 1'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
